// File: rtl/z2_bus_master.sv
// Zorro II / 68000 bus initiator: arbitrates with BR/BG/BGACK, runs one async read or write, reports via done.
// Busy from accept to done; req ignored while busy or during the done pulse; no backpressure beyond that.
module z2_bus_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 23
) (
  input  logic              MEMCLK,
  input  logic              RESET,
  input  logic              req,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_be,
  input  logic [15:0]       req_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              timeout,
  output logic [15:0]       rdata,
  output logic              BR_n,
  input  logic              BG_n,
  output logic              BGACK_n,
  input  logic              AS_n_in,
  input  logic              DTACK_n,
  input  logic              BERR_n,
  input  logic [15:0]       DIN,
  output logic [ADDR_W-1:0] ADDR_OUT,
  output logic              AS_n,
  output logic              UDS_n,
  output logic              LDS_n,
  output logic              RW,
  output logic              BUS_OE,
  output logic [15:0]       DOUT,
  output logic              DOE
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_ADDR, S_STRB, S_WAIT, S_END, S_REL} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          be_q, be_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d, tout_q, tout_d;
  logic [15:0]         rdata_q, rdata_d;
  logic                br_n_q, br_n_d, bgack_n_q, bgack_n_d;
  logic                as_n_q, as_n_d, uds_n_q, uds_n_d, lds_n_q, lds_n_d;
  logic                rwo_q, rwo_d, bus_oe_q, bus_oe_d, doe_q, doe_d;
  logic [ADDR_W-1:0]   addr_out_q, addr_out_d;
  logic [15:0]         dout_q, dout_d;

  logic bg_s, as_s, dt_s, berr_s, released;

  // Synchroniser lanes: [3]=BG_n, [2]=AS_n_in, [1]=DTACK_n, [0]=BERR_n
  assign sync1_d  = {BG_n, AS_n_in, DTACK_n, BERR_n};
  assign sync2_d  = sync1_q;
  assign bg_s     = sync2_q[3];
  assign as_s     = sync2_q[2];
  assign dt_s     = sync2_q[1];
  assign berr_s   = sync2_q[0];
  assign released = dt_s & berr_s;

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    tout_d     = tout_q;
    rdata_d    = rdata_q;
    br_n_d     = br_n_q;
    bgack_n_d  = bgack_n_q;
    as_n_d     = as_n_q;
    uds_n_d    = uds_n_q;
    lds_n_d    = lds_n_q;
    rwo_d      = rwo_q;
    bus_oe_d   = bus_oe_q;
    addr_out_d = addr_out_q;
    dout_d     = dout_q;
    doe_d      = doe_q;

    case (state_q)
      S_IDLE: begin
        if (req && !done_q) begin
          rw_d    = req_rw;
          addr_d  = req_addr;
          be_d    = req_be;
          wdata_d = req_wdata;
          err_d   = 1'b0;
          tout_d  = 1'b0;
          if (req_be == 2'b00) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            busy_d  = 1'b1;
            br_n_d  = 1'b0;
            state_d = S_ARB;
          end
        end
      end
      S_ARB: begin
        // Only take the bus once the previous owner has dropped AS and its slave has let go of DTACK
        if (!bg_s && as_s && dt_s) begin
          bgack_n_d  = 1'b0;
          br_n_d     = 1'b1;
          bus_oe_d   = 1'b1;
          addr_out_d = addr_q;
          rwo_d      = rw_q;
          dout_d     = wdata_q;
          doe_d      = ~rw_q;
          as_n_d     = 1'b0;
          if (rw_q) begin
            uds_n_d = ~be_q[1];
            lds_n_d = ~be_q[0];
          end
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rw_q) begin
          state_d = S_WAIT;
        end else begin
          uds_n_d = ~be_q[1];
          lds_n_d = ~be_q[0];
          state_d = S_STRB;
        end
      end
      S_STRB: state_d = S_WAIT;
      S_WAIT: begin
        if (!berr_s) begin
          err_d   = 1'b1;
          state_d = S_END;
        end else if (!dt_s) begin
          if (rw_q) rdata_d = DIN;
          state_d = S_END;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          tout_d  = 1'b1;
          state_d = S_END;
        end
        if (state_d == S_END) begin
          as_n_d  = 1'b1;
          uds_n_d = 1'b1;
          lds_n_d = 1'b1;
        end
      end
      S_END: state_d = S_REL;
      S_REL: begin
        if (released || cnt_q == CNT_LAST) begin
          if (!released) begin
            err_d  = 1'b1;
            tout_d = 1'b1;
          end
          doe_d     = 1'b0;
          bus_oe_d  = 1'b0;
          bgack_n_d = 1'b1;
          rwo_d     = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q)          cnt_d = '0;
    else if (cnt_q == {CNT_W{1'b1}}) cnt_d = cnt_q;
    else                             cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge MEMCLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sync1_q    <= 4'hF;
      sync2_q    <= 4'hF;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= 2'b00;
      wdata_q    <= 16'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tout_q     <= 1'b0;
      rdata_q    <= 16'h0;
      br_n_q     <= 1'b1;
      bgack_n_q  <= 1'b1;
      as_n_q     <= 1'b1;
      uds_n_q    <= 1'b1;
      lds_n_q    <= 1'b1;
      rwo_q      <= 1'b1;
      bus_oe_q   <= 1'b0;
      addr_out_q <= '0;
      dout_q     <= 16'h0;
      doe_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tout_q     <= tout_d;
      rdata_q    <= rdata_d;
      br_n_q     <= br_n_d;
      bgack_n_q  <= bgack_n_d;
      as_n_q     <= as_n_d;
      uds_n_q    <= uds_n_d;
      lds_n_q    <= lds_n_d;
      rwo_q      <= rwo_d;
      bus_oe_q   <= bus_oe_d;
      addr_out_q <= addr_out_d;
      dout_q     <= dout_d;
      doe_q      <= doe_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign timeout  = tout_q;
  assign rdata    = rdata_q;
  assign BR_n     = br_n_q;
  assign BGACK_n  = bgack_n_q;
  assign ADDR_OUT = addr_out_q;
  assign AS_n     = as_n_q;
  assign UDS_n    = uds_n_q;
  assign LDS_n    = lds_n_q;
  assign RW       = rwo_q;
  assign BUS_OE   = bus_oe_q;
  assign DOUT     = dout_q;
  assign DOE      = doe_q;

endmodule

// File: tb/tb_z2_bus_master.sv
// Directed bench for z2_bus_master: bus arbiter and slave models plus a completion scoreboard.
module tb_z2_bus_master;
  localparam int TO = 16;

  logic        MEMCLK = 1'b0;
  logic        RESET  = 1'b1;
  logic        req = 1'b0, req_rw = 1'b0;
  logic [22:0] req_addr = '0;
  logic [1:0]  req_be = 2'b00;
  logic [15:0] req_wdata = '0;
  logic        busy, done, err, timeout;
  logic [15:0] rdata;
  logic        BR_n, BGACK_n, AS_n, UDS_n, LDS_n, RW, BUS_OE, DOE;
  logic        BG_n = 1'b1, DTACK_n = 1'b1, BERR_n = 1'b1;
  logic        AS_n_in;
  logic        other_as_n = 1'b1;
  logic [15:0] DIN = '0;
  logic [22:0] ADDR_OUT;
  logic [15:0] DOUT;

  z2_bus_master #(.TIMEOUT_CYCLES(TO), .ADDR_W(23)) dut (
    .MEMCLK(MEMCLK), .RESET(RESET), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_be(req_be), .req_wdata(req_wdata), .busy(busy), .done(done), .err(err),
    .timeout(timeout), .rdata(rdata), .BR_n(BR_n), .BG_n(BG_n), .BGACK_n(BGACK_n),
    .AS_n_in(AS_n_in), .DTACK_n(DTACK_n), .BERR_n(BERR_n), .DIN(DIN),
    .ADDR_OUT(ADDR_OUT), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n), .RW(RW),
    .BUS_OE(BUS_OE), .DOUT(DOUT), .DOE(DOE)
  );

  always #5 MEMCLK = ~MEMCLK;

  // Pin-level AS_n: our strobe when driving, wire-ANDed with another master
  assign AS_n_in = other_as_n & (AS_n | ~BUS_OE);

  int compared = 0, mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct packed {logic [15:0] rdata; logic err; logic tout;} exp_t;
  exp_t sb[$];

  // Arbiter: grants bg_delay cycles after BR_n falls, withdraws when BR_n rises
  int bg_delay = 0, bg_cnt = 0;
  always @(negedge MEMCLK) begin
    if (BR_n) begin
      bg_cnt = 0;
      BG_n   = 1'b1;
    end else if (bg_cnt >= bg_delay) BG_n = 1'b0;
    else bg_cnt++;
  end

  // Slave: mode 0 DTACK, 1 BERR, 2 silent; responds slv_dly cycles after AS_n low
  int slv_mode = 0, slv_dly = 1, berr_hold = 1, as_cnt = 0, berr_rel = 0;
  logic [15:0] slv_data = '0;
  always @(negedge MEMCLK) begin
    if (BUS_OE && !AS_n) begin
      as_cnt++;
      berr_rel = 0;
      if (slv_mode == 0 && as_cnt >= slv_dly) begin
        DTACK_n = 1'b0;
        DIN     = slv_data;
      end
      if (slv_mode == 1 && as_cnt >= slv_dly) BERR_n = 1'b0;
    end else begin
      as_cnt  = 0;
      DTACK_n = 1'b1;
      if (!BERR_n) begin
        berr_rel++;
        if (berr_rel >= berr_hold) BERR_n = 1'b1;
      end
    end
  end

  // Recorder and scoreboard, sampled 1 time unit after each rising edge
  int cyc = 0, as_fall = 0, uds_fall = 0, lds_fall = 0, doe_rise = 0, berr_rise = 0;
  int as_low_cnt = 0, lds_low_cnt = 0, br_low_cnt = 0, bgack_low_cnt = 0;
  int done_cnt = 0, done_cyc = 0;
  logic [22:0] addr_at = '0;
  logic [15:0] dout_at = '0;
  logic rw_at = 1'b1, as_at_berr = 1'b0;
  logic prev_as = 1'b1, prev_uds = 1'b1, prev_lds = 1'b1, prev_doe = 1'b0;
  logic prev_berr = 1'b1, prev_done = 1'b0;
  always begin
    exp_t e;
    @(posedge MEMCLK);
    #1;
    cyc++;
    if (prev_as && !AS_n) begin as_fall = cyc; as_low_cnt = 0; end
    if (!AS_n) as_low_cnt++;
    if (prev_uds && !UDS_n) begin
      uds_fall = cyc; addr_at = ADDR_OUT; rw_at = RW; dout_at = DOUT;
    end
    if (prev_lds && !LDS_n) lds_fall = cyc;
    if (!LDS_n) lds_low_cnt++;
    if (!prev_doe && DOE) doe_rise = cyc;
    if (!prev_berr && BERR_n) begin berr_rise = cyc; as_at_berr = AS_n; end
    if (!BR_n) br_low_cnt++;
    if (!BGACK_n) bgack_low_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
      compared++;
      assert (sb.size() != 0) else begin
        mismatched++;
        $error("FAIL sb_unexpected_done: observed done=1 expected no pending transfer");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rdata", {16'd0, rdata}, {16'd0, e.rdata});
        chk("err", {31'd0, err}, {31'd0, e.err});
        chk("timeout", {31'd0, timeout}, {31'd0, e.tout});
      end
    end
    prev_as = AS_n; prev_uds = UDS_n; prev_lds = LDS_n; prev_doe = DOE;
    prev_berr = BERR_n; prev_done = done;
  end

  int pre_done = 0;
  logic [15:0] exp_rdata = '0;

  task automatic issue(input logic rw, input logic [22:0] a, input logic [1:0] be,
                       input logic [15:0] wd);
    @(negedge MEMCLK);
    pre_done  = done_cnt;
    req       = 1'b1;
    req_rw    = rw;
    req_addr  = a;
    req_be    = be;
    req_wdata = wd;
    @(negedge MEMCLK);
    req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == pre_done && n < budget) begin
      @(negedge MEMCLK);
      n++;
    end
    compared++;
    assert (done_cnt != pre_done) else begin
      mismatched++;
      $error("FAIL %s: observed no done within %0d cycles expected done", tag, budget);
    end
  endtask

  initial begin
    int snap, snap2, n;

    // Reset values
    repeat (3) @(negedge MEMCLK);
    chk("reset_ctl", {20'd0, BR_n, BGACK_n, AS_n, UDS_n, LDS_n, RW, BUS_OE, DOE,
                      busy, done, err, timeout}, 32'b1111_1100_0000);
    chk("reset_rdata", {16'd0, rdata}, 32'd0);
    chk("reset_addr", {9'd0, ADDR_OUT}, 32'd0);
    chk("reset_dout", {16'd0, DOUT}, 32'd0);
    RESET = 1'b0;
    repeat (2) @(negedge MEMCLK);

    // Read word, grant after 3 cycles, DTACK 4 cycles after AS_n
    bg_delay = 3; slv_mode = 0; slv_dly = 4; slv_data = 16'hA55A;
    exp_rdata = 16'hA55A;
    sb.push_back('{16'hA55A, 1'b0, 1'b0});
    issue(1'b1, 23'h012345, 2'b11, 16'h0);
    wait_done("rd_word_done", 100);
    chk("rd_uds_with_as", uds_fall, as_fall);
    chk("rd_lds_with_as", lds_fall, as_fall);

    // Write upper byte
    repeat (2) @(negedge MEMCLK);
    bg_delay = 1; slv_dly = 2;
    snap = lds_low_cnt;
    sb.push_back('{exp_rdata, 1'b0, 1'b0});
    issue(1'b0, 23'h100000, 2'b10, 16'h1234);
    wait_done("wr_byte_done", 100);
    chk("wr_data_before_strobe", uds_fall - doe_rise, 1);
    chk("wr_lds_idle", lds_low_cnt - snap, 0);
    chk("wr_addr", {9'd0, addr_at}, 32'h100000);
    chk("wr_rw", {31'd0, rw_at}, 32'd0);
    chk("wr_dout", {16'd0, dout_at}, 32'h1234);
    chk("wr_release", {28'd0, BGACK_n, BUS_OE, DOE, RW}, 32'b1001);

    // Bus error, BERR held a few cycles past strobe negation
    repeat (2) @(negedge MEMCLK);
    slv_mode = 1; slv_dly = 3; berr_hold = 4;
    sb.push_back('{exp_rdata, 1'b1, 1'b0});
    issue(1'b1, 23'h000005, 2'b01, 16'h0);
    wait_done("berr_done", 100);
    chk("berr_done_after_release", {31'd0, done_cyc > berr_rise}, 32'd1);
    chk("berr_strobes_negated", {31'd0, as_at_berr}, 32'd1);

    // Silent slave: timeout after TO cycles in WAIT (plus the ADDR cycle with AS low)
    repeat (2) @(negedge MEMCLK);
    slv_mode = 2;
    sb.push_back('{exp_rdata, 1'b1, 1'b1});
    issue(1'b1, 23'h000010, 2'b11, 16'h0);
    wait_done("tout_done", 200);
    chk("tout_as_low_cycles", as_low_cnt, TO + 1);

    // Another master still owns AS_n while BG is low; busy req is ignored
    repeat (2) @(negedge MEMCLK);
    other_as_n = 1'b0; bg_delay = 0; slv_mode = 0; slv_dly = 2; slv_data = 16'h0F0F;
    snap = bgack_low_cnt;
    exp_rdata = 16'h0F0F;
    sb.push_back('{16'h0F0F, 1'b0, 1'b0});
    issue(1'b1, 23'h000020, 2'b11, 16'h0);
    repeat (6) @(negedge MEMCLK);
    req = 1'b1; req_rw = 1'b0; req_addr = 23'h7FFFFF; req_be = 2'b11;
    @(negedge MEMCLK);
    req = 1'b0;
    repeat (3) @(negedge MEMCLK);
    chk("arb_bgack_held", bgack_low_cnt - snap, 0);
    chk("arb_busy", {31'd0, busy}, 32'd1);
    other_as_n = 1'b1;
    wait_done("arb_done", 100);
    // req during the done cycle must be dropped
    snap  = br_low_cnt;
    snap2 = done_cnt;
    req = 1'b1; req_rw = 1'b1; req_addr = 23'h000030; req_be = 2'b11;
    @(negedge MEMCLK);
    req = 1'b0;
    repeat (30) @(negedge MEMCLK);
    chk("done_cycle_req_ignored", done_cnt - snap2, 0);
    chk("done_cycle_no_br", br_low_cnt - snap, 0);
    chk("idle_not_busy", {31'd0, busy}, 32'd0);

    // Zero byte enables: immediate error, no bus request
    snap = br_low_cnt;
    sb.push_back('{exp_rdata, 1'b1, 1'b0});
    issue(1'b1, 23'h000040, 2'b00, 16'h0);
    wait_done("be0_done", 10);
    chk("be0_no_br", br_low_cnt - snap, 0);

    // Reset while waiting for a slave that never answers
    repeat (2) @(negedge MEMCLK);
    slv_mode = 2;
    issue(1'b1, 23'h000777, 2'b11, 16'h0);
    n = 0;
    while (!(AS_n == 1'b0 && as_low_cnt >= 3) && n < 50) begin
      @(negedge MEMCLK);
      n++;
    end
    chk("rst_reached_wait", {31'd0, AS_n}, 32'd0);
    RESET = 1'b1;
    #1;
    chk("rst_async_release", {27'd0, AS_n, BUS_OE, DOE, BGACK_n, busy}, 32'b10010);
    @(negedge MEMCLK);
    RESET = 1'b0;
    exp_rdata = 16'h0;
    chk("rst_rdata_cleared", {16'd0, rdata}, {16'd0, exp_rdata});
    repeat (3) @(negedge MEMCLK);

    slv_mode = 0; slv_dly = 2; slv_data = 16'h5AA5;
    exp_rdata = 16'h5AA5;
    sb.push_back('{16'h5AA5, 1'b0, 1'b0});
    issue(1'b1, 23'h000123, 2'b11, 16'h0);
    wait_done("post_rst_done", 100);
    repeat (3) @(negedge MEMCLK);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/z2_bus_master.md
Name: z2_bus_master

Overview:
- Zorro II / 68000-style bus initiator; the master-side counterpart of the card's slave decoder and DTACK state machine.
- Takes single-word/byte transfer requests from on-card logic (DMA engine, self-test) and wins the bus via BR_n/BG_n/BGACK_n.
- Runs one asynchronous 68000 read or write cycle, then returns data/status.
- All bus inputs are synchronised into MEMCLK. Tristate buffers live at top level; this block only supplies the enables.

Parameters:
- TIMEOUT_CYCLES, 255: MEMCLK cycles to wait for DTACK_n/BERR_n, and for slave release, before aborting with error.
- ADDR_W, 23: width of the word address (A23..A1).

Ports:
- MEMCLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- req  in  1  one-cycle request strobe; sampled only when busy=0.
- req_rw  in  1  1=read, 0=write.
- req_addr  in  ADDR_W  word address A23..A1.
- req_be  in  2  byte enables {upper,lower}.
- req_wdata  in  16  write data.
- busy  out  1  request accepted, not yet finished.
- done  out  1  one-cycle completion pulse.
- err  out  1  status of the last transfer, valid with done; held until the next accept.
- timeout  out  1  status of the last transfer: error was a timeout.
- rdata  out  16  read data, valid with done.
- BR_n  out  1  bus request.
- BG_n  in  1  bus grant (async).
- BGACK_n  out  1  bus grant acknowledge.
- AS_n_in  in  1  bus AS_n as seen on the pins (async).
- DTACK_n  in  1  async.
- BERR_n  in  1  async.
- DIN  in  16  data bus in.
- ADDR_OUT  out  ADDR_W  address drive value.
- AS_n  out  1  address strobe drive value.
- UDS_n  out  1  upper data strobe drive value.
- LDS_n  out  1  lower data strobe drive value.
- RW  out  1  read/write drive value.
- BUS_OE  out  1  enable for the ADDR/AS/UDS/LDS/RW drivers.
- DOUT  out  16  write data.
- DOE  out  1  data bus output enable.

Behaviour:
- Reset: BR_n, BGACK_n, AS_n, UDS_n, LDS_n and RW = 1; BUS_OE, DOE, busy, done, err and timeout = 0; rdata, ADDR_OUT and DOUT = 0; state IDLE. Reset asserted mid-cycle releases the bus in the same instant (asynchronous).
- Input synchronisers: BG_n, AS_n_in, DTACK_n and BERR_n each pass through 2 flops, reset to 1. All decisions use the synced versions.
- Cycle counter: 8+ bits, cleared on every state entry.
- States: IDLE, ARB, ADDR, STRB, WAIT, END, REL.
- IDLE:
  - On req: latch rw, addr, be and wdata, and set busy=1.
  - Clear err and timeout.
  - If req_be=00: skip the bus, set done=1 and err=1 next cycle, busy=0.
  - Else: BR_n=0, go to ARB.
- ARB: wait for BG sync=0 AND AS_in sync=1 AND DTACK sync=1. Then set:
  - BGACK_n=0, BR_n=1, BUS_OE=1;
  - ADDR_OUT=addr, RW=rw;
  - DOUT=wdata and DOE=~rw.
  - Go to ADDR.
  - No timeout in ARB.
- ADDR: AS_n=0.
  - Read: assert the UDS_n/LDS_n selected by be in the same cycle, then go to WAIT.
  - Write: go to STRB.
- STRB (write only): assert the selected strobes, then go to WAIT. Data is therefore stable 1 cycle before the strobes.
- WAIT:
  - Priority BERR sync=0 > DTACK sync=0 > counter==TIMEOUT_CYCLES-1.
  - BERR: err=1, go to END.
  - DTACK: for a read, rdata<=DIN (all 16 bits, regardless of be), go to END.
  - Timeout: err=1, timeout=1, go to END.
  - DTACK and BERR seen together: treated as BERR, rdata unchanged.
- END: AS_n, UDS_n and LDS_n = 1; go to REL.
- REL: wait for DTACK sync=1 AND BERR sync=1, or the counter to expire. Then, in one cycle:
  - DOE=0, BUS_OE=0, BGACK_n=1, RW=1;
  - done=1, busy=0;
  - go to IDLE.
  - Slave-release expiry sets timeout=1 and err=1.
- Handshake: done is high for exactly 1 cycle. req is ignored while busy=1 or in the done cycle. A new req is accepted the cycle after done.
- Latency (ideal, BG already low, DTACK returned immediately by the slave): read has 2 cycles of sync in WAIT; total req->done ≈ 9 cycles for a read, 10 for a write.

Test Plan:
- Read word, BG low after 3 cycles, slave asserts DTACK 4 cycles after AS_n low with DIN=0xA55A -> rdata=0xA55A, err=0; UDS_n/LDS_n low together with AS_n; done one cycle.
- Write byte, be=10, wdata=0x1234, addr=0x200000>>1 -> ADDR_OUT=0x100000, RW=0, DOE=1 one cycle before UDS_n=0, LDS_n stays 1; DTACK -> done, err=0, bus released with BGACK_n=1.
- BERR_n low with no DTACK during WAIT -> err=1, timeout=0, strobes negate, done after BERR_n returns high.
- No DTACK and no BERR, TIMEOUT_CYCLES=16 -> AS_n low for 16 synced-WAIT cycles, then err=1, timeout=1, done.
- Another master holds AS_n_in low while BG_n=0 -> BGACK_n stays 1 until AS_n_in sync high; req pulsed while busy is ignored; req_be=00 -> done+err with no BR_n.
- RESET asserted while in WAIT -> immediately AS_n=1, BUS_OE=0, DOE=0, BGACK_n=1, busy=0; after reset, a new read completes normally.
